pipeline_hazard_controller: RTL

//  Sequences the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/hazard_detect_unit.sv | 14 +
 rtl/pipeline_hazard_controller.sv | 99 +++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and register constants for the pipeline hazard controller
package pipe_ctrl_pkg;
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERROR    = 2'd2;
    localparam logic [4:0] REG_ZERO    = 5'd0;
    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        MEM_WAIT = ST_MEM_WAIT,
        ERROR    = ST_ERROR
    } state_e;
endpackage

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: combinational load-use hazard compare
// Ports: rs/rt = ID source regs, mem_read/write_reg = load in EX, load_use = hazard present
module hazard_detect_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       mem_read,
    input  logic [4:0] write_reg,
    output logic       load_use
);
    // r0 is hardwired zero, so a load targeting it never creates a real dependency
    assign load_use = mem_read & (write_reg != REG_ZERO) & ((write_reg == rs) | (write_reg == rt));
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: 5-stage pipeline enables/flushes for load-use, branches and variable-latency memory
// Ports: hazard inputs from IF/ID, ID/EX, EX/MEM; mem_ready/mem_req handshake;
//        per-stage enables, flushes, MEM/WB bubble; sticky mem_error; saturating stall_cycles
module pipeline_hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_Rs,
    input  logic [4:0]       IF_ID_Rt,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_WriteReg,
    input  logic             branch_taken,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_MemWrite,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PC_En,
    output logic             IF_ID_En,
    output logic             IF_ID_Flush,
    output logic             ID_EX_En,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_En,
    output logic             MEM_WB_Bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             mem_error_q, mem_error_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             load_use, mem_access, frozen, run;

    hazard_detect_unit u_hdu (
        .rs        (IF_ID_Rs),
        .rt        (IF_ID_Rt),
        .mem_read  (ID_EX_MemRead),
        .write_reg (ID_EX_WriteReg),
        .load_use  (load_use)
    );

    always_comb begin
        mem_access  = EX_MEM_MemRead | EX_MEM_MemWrite;
        // A zero-wait access (ready in the request cycle) never freezes
        frozen      = (state_q == ERROR) | (state_q == MEM_WAIT & ~mem_ready) | (state_q == IDLE & mem_access & ~mem_ready);
        run         = rst_n & ~frozen;
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        case (state_q)
            IDLE: if (mem_access & ~mem_ready) begin
                state_d    = MEM_WAIT;
                wait_cnt_d = WW'(1);
            end
            MEM_WAIT: if (mem_ready) begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end else if (wait_cnt_q == WW'(MEM_TIMEOUT)) begin
                state_d     = ERROR;
                mem_error_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + WW'(1);
            end
            default: ;
        endcase
        mem_req       = rst_n & mem_access & (state_q != ERROR);
        // A taken branch squashes the dependent instruction, so load-use is moot
        PC_En         = run & (branch_taken | ~load_use);
        IF_ID_En      = run & (branch_taken | ~load_use);
        IF_ID_Flush   = run & branch_taken;
        ID_EX_En      = run;
        ID_EX_Flush   = run & (branch_taken | load_use);
        EX_MEM_En     = run;
        MEM_WB_Bubble = rst_n & frozen;
        stall_d       = (~PC_En & ~&stall_q) ? stall_q + CNT_W'(1) : stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
            stall_q     <= stall_d;
        end
    end

    assign mem_error    = mem_error_q;
    assign stall_cycles = stall_q;
endmodule
